// File: rtl/alu_ops_pkg.sv
// Shared ALU operation codes, MIPS opcode/funct encodings and the helper that
// tells the hazard logic which register fields an operation actually reads.
package alu_ops_pkg;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_ADDI = 5'd1;
  localparam logic [4:0] ALU_SUB  = 5'd2;
  localparam logic [4:0] ALU_MUL  = 5'd3;
  localparam logic [4:0] ALU_LW   = 5'd4;
  localparam logic [4:0] ALU_SW   = 5'd5;
  localparam logic [4:0] ALU_SB   = 5'd6;
  localparam logic [4:0] ALU_LH   = 5'd7;
  localparam logic [4:0] ALU_LB   = 5'd8;
  localparam logic [4:0] ALU_SH   = 5'd9;
  localparam logic [4:0] ALU_BGEZ = 5'd10;
  localparam logic [4:0] ALU_BEQ  = 5'd11;
  localparam logic [4:0] ALU_BNE  = 5'd12;
  localparam logic [4:0] ALU_BGTZ = 5'd13;
  localparam logic [4:0] ALU_BLEZ = 5'd14;
  localparam logic [4:0] ALU_BLTZ = 5'd15;
  localparam logic [4:0] ALU_J    = 5'd16;
  localparam logic [4:0] ALU_JR   = 5'd17;
  localparam logic [4:0] ALU_JAL  = 5'd18;
  localparam logic [4:0] ALU_AND  = 5'd19;
  localparam logic [4:0] ALU_ANDI = 5'd20;
  localparam logic [4:0] ALU_OR   = 5'd21;
  localparam logic [4:0] ALU_NOR  = 5'd22;
  localparam logic [4:0] ALU_XOR  = 5'd23;
  localparam logic [4:0] ALU_ORI  = 5'd24;
  localparam logic [4:0] ALU_XORI = 5'd25;
  localparam logic [4:0] ALU_SLL  = 5'd26;
  localparam logic [4:0] ALU_SRL  = 5'd27;
  localparam logic [4:0] ALU_SLT  = 5'd28;
  localparam logic [4:0] ALU_SLTI = 5'd29;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_MUL     = 6'h1C;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] F_SLL = 6'h00;
  localparam logic [5:0] F_SRL = 6'h02;
  localparam logic [5:0] F_MUL = 6'h02;
  localparam logic [5:0] F_JR  = 6'h08;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_XOR = 6'h26;
  localparam logic [5:0] F_NOR = 6'h27;
  localparam logic [5:0] F_SLT = 6'h2A;

  // Returns {rs_read, rt_read} for a decoded operation.
  function automatic logic [1:0] src_usage(input logic [4:0] code);
    logic rs_read;
    logic rt_read;
    rs_read = !(code inside {ALU_J, ALU_JAL, ALU_SLL, ALU_SRL});
    rt_read = code inside {ALU_ADD, ALU_SUB, ALU_MUL, ALU_JR, ALU_AND, ALU_OR,
                           ALU_NOR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SLT,
                           ALU_SW, ALU_SB, ALU_SH, ALU_BEQ, ALU_BNE};
    return {rs_read, rt_read};
  endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// IF/ID-to-ID/EX bundle: the master drives the instruction side and reads the
// stall and issued fields, the slave is the issue stage itself.
interface alu_issue_stage_if #(parameter int DATA_W = 32);
  logic              in_valid;
  logic [31:0]       instr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              hold_ex;
  logic              flush;
  logic              stall_out;
  logic              issue_valid;
  logic [4:0]        alu_control;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] shamt;
  logic [4:0]        dest_reg;
  logic              reg_write;
  logic              mem_read;
  logic              mem_write;
  logic              illegal;

  modport master (
    output in_valid, instr, rs_data, rt_data, hold_ex, flush,
    input  stall_out, issue_valid, alu_control, alu_a, alu_b, shamt,
           dest_reg, reg_write, mem_read, mem_write, illegal
  );

  modport slave (
    input  in_valid, instr, rs_data, rt_data, hold_ex, flush,
    output stall_out, issue_valid, alu_control, alu_a, alu_b, shamt,
           dest_reg, reg_write, mem_read, mem_write, illegal
  );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational MIPS decoder: ALU code, immediate, destination, memory flags
// and the register fields the instruction reads.
module alu_op_decode #(
  parameter int DATA_W      = 32,
  parameter int ZERO_IS_NOP = 1
) (
  input  logic [31:0]       instr,
  output logic [4:0]        alu_code,
  output logic [DATA_W-1:0] imm_ext,
  output logic              b_is_rt,
  output logic [4:0]        dest,
  output logic              reg_write,
  output logic              mem_read,
  output logic              mem_write,
  output logic              uses_rs,
  output logic              uses_rt,
  output logic              issue_ok,
  output logic              illegal
);
  import alu_ops_pkg::*;

  logic [5:0] op;
  logic [5:0] fn;
  logic [4:0] rt;
  logic [4:0] rd;
  logic known, rfmt, wr_rd, wr_rt, wr_ra, zext, is_load, is_store, is_cmp_br;
  logic is_nop;

  assign op = instr[31:26];
  assign fn = instr[5:0];
  assign rt = instr[20:16];
  assign rd = instr[15:11];

  // mul shares the register format of op-0 instructions: rd destination, rt operand.
  always_comb begin
    known     = 1'b1;
    rfmt      = 1'b0;
    wr_rt     = 1'b0;
    wr_ra     = 1'b0;
    zext      = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_cmp_br = 1'b0;
    alu_code  = ALU_ADD;
    case (op)
      OP_SPECIAL: begin
        rfmt = 1'b1;
        case (fn)
          F_ADD:   alu_code = ALU_ADD;
          F_SUB:   alu_code = ALU_SUB;
          F_JR:    alu_code = ALU_JR;
          F_AND:   alu_code = ALU_AND;
          F_OR:    alu_code = ALU_OR;
          F_NOR:   alu_code = ALU_NOR;
          F_XOR:   alu_code = ALU_XOR;
          F_SLL:   alu_code = ALU_SLL;
          F_SRL:   alu_code = ALU_SRL;
          F_SLT:   alu_code = ALU_SLT;
          default: known = 1'b0;
        endcase
      end
      OP_MUL: begin
        rfmt     = 1'b1;
        alu_code = ALU_MUL;
        known    = (fn == F_MUL);
      end
      OP_REGIMM: begin
        if (rt == 5'd1)      alu_code = ALU_BGEZ;
        else if (rt == 5'd0) alu_code = ALU_BLTZ;
        else                 known = 1'b0;
      end
      OP_ADDI: begin alu_code = ALU_ADDI; wr_rt = 1'b1; end
      OP_SLTI: begin alu_code = ALU_SLTI; wr_rt = 1'b1; end
      OP_ANDI: begin alu_code = ALU_ANDI; wr_rt = 1'b1; zext = 1'b1; end
      OP_ORI:  begin alu_code = ALU_ORI;  wr_rt = 1'b1; zext = 1'b1; end
      OP_XORI: begin alu_code = ALU_XORI; wr_rt = 1'b1; zext = 1'b1; end
      OP_LW:   begin alu_code = ALU_LW; wr_rt = 1'b1; is_load = 1'b1; end
      OP_LH:   begin alu_code = ALU_LH; wr_rt = 1'b1; is_load = 1'b1; end
      OP_LB:   begin alu_code = ALU_LB; wr_rt = 1'b1; is_load = 1'b1; end
      OP_SW:   begin alu_code = ALU_SW; is_store = 1'b1; end
      OP_SH:   begin alu_code = ALU_SH; is_store = 1'b1; end
      OP_SB:   begin alu_code = ALU_SB; is_store = 1'b1; end
      OP_BEQ:  begin alu_code = ALU_BEQ; is_cmp_br = 1'b1; end
      OP_BNE:  begin alu_code = ALU_BNE; is_cmp_br = 1'b1; end
      OP_BGTZ: alu_code = ALU_BGTZ;
      OP_BLEZ: alu_code = ALU_BLEZ;
      OP_J:    alu_code = ALU_J;
      OP_JAL:  begin alu_code = ALU_JAL; wr_ra = 1'b1; end
      default: known = 1'b0;
    endcase
  end

  assign wr_rd = rfmt & (alu_code != ALU_JR);

  always_comb begin
    dest = 5'd0;
    if (wr_rd)      dest = rd;
    else if (wr_rt) dest = rt;
    else if (wr_ra) dest = 5'd31;
  end

  assign reg_write = known & (wr_rd | wr_rt | wr_ra) & (dest != 5'd0);
  assign mem_read  = known & is_load;
  assign mem_write = known & is_store;
  assign b_is_rt   = rfmt | is_cmp_br;
  assign imm_ext   = zext ? {{(DATA_W-16){1'b0}}, instr[15:0]}
                          : {{(DATA_W-16){instr[15]}}, instr[15:0]};
  assign {uses_rs, uses_rt} = known ? src_usage(alu_code) : 2'b00;
  assign is_nop    = (ZERO_IS_NOP != 0) && (instr == 32'd0);
  assign issue_ok  = known & ~is_nop;
  assign illegal   = ~known;
endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: load-use hazard detection and the ID/EX pipeline register
// with flush > hold > hazard > load priority.
module alu_issue_stage #(
  parameter int DATA_W      = 32,
  parameter int ZERO_IS_NOP = 1
) (
  input logic              clk,
  input logic              rst_n,
  alu_issue_stage_if.slave bus
);
  typedef struct packed {
    logic              valid;
    logic [4:0]        code;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] shamt;
    logic [4:0]        dest;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
  } idex_t;

  idex_t idex_q, idex_d;
  logic  illegal_q;
  logic  hazard;

  logic [4:0]        dec_code;
  logic [DATA_W-1:0] dec_imm;
  logic [4:0]        dec_dest;
  logic dec_b_is_rt, dec_reg_write, dec_mem_read, dec_mem_write;
  logic dec_uses_rs, dec_uses_rt, dec_issue_ok, dec_illegal;

  alu_op_decode #(.DATA_W(DATA_W), .ZERO_IS_NOP(ZERO_IS_NOP)) u_decode (
    .instr     (bus.instr),
    .alu_code  (dec_code),
    .imm_ext   (dec_imm),
    .b_is_rt   (dec_b_is_rt),
    .dest      (dec_dest),
    .reg_write (dec_reg_write),
    .mem_read  (dec_mem_read),
    .mem_write (dec_mem_write),
    .uses_rs   (dec_uses_rs),
    .uses_rt   (dec_uses_rt),
    .issue_ok  (dec_issue_ok),
    .illegal   (dec_illegal)
  );

  // The bubble this inserts drops mem_read, so the stall can never exceed one cycle.
  assign hazard = idex_q.valid & idex_q.mem_read & (idex_q.dest != 5'd0) & bus.in_valid &
                  ((dec_uses_rs & (bus.instr[25:21] == idex_q.dest)) |
                   (dec_uses_rt & (bus.instr[20:16] == idex_q.dest)));

  assign bus.stall_out = hazard | bus.hold_ex;

  always_comb begin
    idex_d = '0;
    if (bus.in_valid & dec_issue_ok & ~hazard) begin
      idex_d.valid     = 1'b1;
      idex_d.code      = dec_code;
      idex_d.a         = bus.rs_data;
      idex_d.b         = dec_b_is_rt ? bus.rt_data : dec_imm;
      idex_d.shamt     = {{(DATA_W-5){1'b0}}, bus.instr[10:6]};
      idex_d.dest      = dec_dest;
      idex_d.reg_write = dec_reg_write;
      idex_d.mem_read  = dec_mem_read;
      idex_d.mem_write = dec_mem_write;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= bus.in_valid & dec_illegal & ~bus.flush & ~bus.hold_ex;
      if (bus.flush)
        idex_q <= '0;
      else if (!bus.hold_ex)
        idex_q <= idex_d;
    end
  end

  assign bus.issue_valid = idex_q.valid;
  assign bus.alu_control = idex_q.code;
  assign bus.alu_a       = idex_q.a;
  assign bus.alu_b       = idex_q.b;
  assign bus.shamt       = idex_q.shamt;
  assign bus.dest_reg    = idex_q.dest;
  assign bus.reg_write   = idex_q.reg_write;
  assign bus.mem_read    = idex_q.mem_read;
  assign bus.mem_write   = idex_q.mem_write;
  assign bus.illegal     = illegal_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomized bench for alu_issue_stage against a mnemonic-table reference model,
// with directed literal checks for the key instruction sequences.
module tb_alu_issue_stage;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_issue_stage_if #(.DATA_W(DATA_W)) bus ();

  alu_issue_stage #(.DATA_W(DATA_W), .ZERO_IS_NOP(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Index in these tables is the ALU code; bgez/bltz keep their rt selector in fn_tab.
  string mn_tab [30] = '{"add","addi","sub","mul","lw","sw","sb","lh","lb","sh",
                         "bgez","beq","bne","bgtz","blez","bltz","j","jr","jal","and",
                         "andi","or","nor","xor","ori","xori","sll","srl","slt","slti"};
  logic [5:0] op_tab [30] = '{6'h00,6'h08,6'h00,6'h1C,6'h23,6'h2B,6'h28,6'h21,6'h20,6'h29,
                              6'h01,6'h04,6'h05,6'h07,6'h06,6'h01,6'h02,6'h00,6'h03,6'h00,
                              6'h0C,6'h00,6'h00,6'h00,6'h0D,6'h0E,6'h00,6'h00,6'h00,6'h0A};
  logic [5:0] fn_tab [30] = '{6'h20,6'h00,6'h22,6'h02,6'h00,6'h00,6'h00,6'h00,6'h00,6'h00,
                              6'h01,6'h00,6'h00,6'h00,6'h00,6'h00,6'h00,6'h08,6'h00,6'h24,
                              6'h00,6'h25,6'h27,6'h26,6'h00,6'h00,6'h00,6'h02,6'h2A,6'h00};

  typedef struct {
    int k;
    bit rfmt, load, store, immz, brt, wr, urs, urt;
    int dst;
  } ref_t;

  int n_checks = 0;
  int n_miss   = 0;
  bit chk_on   = 1'b0;
  bit last_stall;
  ref_t cur, pin;
  bit hz_ref;

  bit        e_valid, e_rw, e_mr, e_mw, e_wr, e_ill;
  int        e_code, e_dest;
  bit [31:0] e_a, e_b, e_sh;

  function automatic ref_t ref_decode(logic [31:0] w);
    ref_t  d;
    string m;
    d.k = -1; d.rfmt = 0; d.load = 0; d.store = 0; d.immz = 0; d.brt = 0;
    d.wr = 0; d.urs = 0; d.urt = 0; d.dst = 0;
    for (int k = 0; k < 30; k++) begin
      if (w[31:26] == op_tab[k] &&
          ((op_tab[k] != 6'h00 && op_tab[k] != 6'h1C) || w[5:0] == fn_tab[k]) &&
          (op_tab[k] != 6'h01 || w[20:16] == fn_tab[k][4:0]))
        d.k = k;
    end
    if (d.k < 0) return d;
    m = mn_tab[d.k];
    d.rfmt  = (w[31:26] == 6'h00) || (m == "mul");
    d.load  = (m == "lw") || (m == "lh") || (m == "lb");
    d.store = (m == "sw") || (m == "sh") || (m == "sb");
    d.immz  = (m == "andi") || (m == "ori") || (m == "xori");
    d.brt   = d.rfmt || (m == "beq") || (m == "bne");
    if (d.rfmt && m != "jr") begin
      d.wr = 1; d.dst = int'(w[15:11]);
    end else if (d.load || m == "addi" || m == "andi" || m == "ori" || m == "xori" || m == "slti") begin
      d.wr = 1; d.dst = int'(w[20:16]);
    end else if (m == "jal") begin
      d.wr = 1; d.dst = 31;
    end
    d.urs = !((m == "j") || (m == "jal") || (m == "sll") || (m == "srl"));
    d.urt = d.brt || d.store;
    return d;
  endfunction

  function automatic logic [31:0] gen_instr(int k);
    logic [4:0]  rs, rt, rd, sh;
    logic [15:0] imm;
    rs  = 5'($urandom_range(0, 3));
    rt  = 5'($urandom_range(0, 3));
    rd  = 5'($urandom_range(0, 3));
    sh  = 5'($urandom_range(0, 31));
    imm = 16'($urandom);
    if (op_tab[k] == 6'h00 || op_tab[k] == 6'h1C)
      return {op_tab[k], rs, rt, rd, sh, fn_tab[k]};
    if (op_tab[k] == 6'h01) rt = fn_tab[k][4:0];
    return {op_tab[k], rs, rt, imm};
  endfunction

  always_comb cur = ref_decode(bus.instr);

  always_comb begin
    hz_ref = 1'b0;
    if (e_valid && e_mr && e_dest != 0 && bus.in_valid && cur.k >= 0)
      hz_ref = (cur.urs && int'(bus.instr[25:21]) == e_dest) ||
               (cur.urt && int'(bus.instr[20:16]) == e_dest);
  end

  // Reference ID/EX register: flush, then hold, then hazard/bubble, else issue.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_valid <= 0; e_rw <= 0; e_mr <= 0; e_mw <= 0; e_wr <= 0; e_ill <= 0;
      e_code <= 0; e_dest <= 0; e_a <= 0; e_b <= 0; e_sh <= 0;
    end else begin
      e_ill <= bus.in_valid && cur.k < 0 && !bus.flush && !bus.hold_ex;
      if (bus.flush || (!bus.hold_ex && (hz_ref || !bus.in_valid || cur.k < 0 || bus.instr == 32'd0))) begin
        e_valid <= 0; e_rw <= 0; e_mr <= 0; e_mw <= 0; e_wr <= 0; e_code <= 0;
      end else if (!bus.hold_ex) begin
        e_valid <= 1;
        e_code  <= cur.k;
        e_a     <= bus.rs_data;
        e_b     <= cur.brt ? bus.rt_data :
                   (cur.immz ? {16'h0, bus.instr[15:0]} : {{16{bus.instr[15]}}, bus.instr[15:0]});
        e_sh    <= {27'h0, bus.instr[10:6]};
        e_dest  <= cur.dst;
        e_wr    <= cur.wr;
        e_rw    <= cur.wr && cur.dst != 0;
        e_mr    <= cur.load;
        e_mw    <= cur.store;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && chk_on) begin
      checkOutput("stall_out",   32'(bus.stall_out),   32'(hz_ref || bus.hold_ex));
      checkOutput("issue_valid", 32'(bus.issue_valid), 32'(e_valid));
      checkOutput("illegal",     32'(bus.illegal),     32'(e_ill));
      checkOutput("reg_write",   32'(bus.reg_write),   32'(e_rw));
      checkOutput("mem_read",    32'(bus.mem_read),    32'(e_mr));
      checkOutput("mem_write",   32'(bus.mem_write),   32'(e_mw));
      checkOutput("alu_control", 32'(bus.alu_control), 32'(e_code));
      if (e_valid) begin
        checkOutput("alu_a", bus.alu_a, e_a);
        checkOutput("alu_b", bus.alu_b, e_b);
        checkOutput("shamt", bus.shamt, e_sh);
        if (e_wr) checkOutput("dest_reg", 32'(bus.dest_reg), 32'(e_dest));
      end
    end
  end

  task automatic applyStimulus(input bit v, input logic [31:0] w, input logic [31:0] a,
                               input logic [31:0] b, input bit hold, input bit fl);
    bus.in_valid = v;
    bus.instr    = w;
    bus.rs_data  = a;
    bus.rt_data  = b;
    bus.hold_ex  = hold;
    bus.flush    = fl;
    #2;
    last_stall = bus.stall_out;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_valid = 0; bus.instr = 0; bus.rs_data = 0; bus.rt_data = 0;
    bus.hold_ex = 0; bus.flush = 0;

    pin = ref_decode(32'h2008FFFB);
    checkOutput("pin_addi_code", 32'(pin.k), 32'd1);
    checkOutput("pin_addi_dst", 32'(pin.dst), 32'd8);
    pin = ref_decode(32'h35498000);
    checkOutput("pin_ori_code", 32'(pin.k), 32'd24);
    checkOutput("pin_ori_zext", 32'(pin.immz), 32'd1);
    pin = ref_decode(32'hFC000000);
    checkOutput("pin_undef", 32'(pin.k), 32'hFFFF_FFFF);

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid", 32'(bus.issue_valid), 32'd0);
    checkOutput("rst_ctrl",  32'(bus.alu_control), 32'd0);
    checkOutput("rst_rw",    32'(bus.reg_write), 32'd0);
    checkOutput("rst_stall", 32'(bus.stall_out), 32'd0);
    rst_n = 1;
    chk_on = 1;

    applyStimulus(1, 32'h2008FFFB, 32'h0, 32'h1234, 0, 0);
    checkOutput("addi_ctrl",  32'(bus.alu_control), 32'd1);
    checkOutput("addi_b",     bus.alu_b, 32'hFFFF_FFFB);
    checkOutput("addi_dest",  32'(bus.dest_reg), 32'd8);
    checkOutput("addi_rw",    32'(bus.reg_write), 32'd1);
    checkOutput("addi_valid", 32'(bus.issue_valid), 32'd1);

    applyStimulus(1, 32'h35498000, 32'h55, 32'h66, 0, 0);
    checkOutput("ori_ctrl", 32'(bus.alu_control), 32'd24);
    checkOutput("ori_b",    bus.alu_b, 32'h0000_8000);

    applyStimulus(1, 32'h000A4900, 32'h7, 32'h8, 0, 0);
    checkOutput("sll_ctrl",  32'(bus.alu_control), 32'd26);
    checkOutput("sll_shamt", bus.shamt, 32'd4);
    checkOutput("sll_dest",  32'(bus.dest_reg), 32'd9);

    applyStimulus(1, 32'h8E080000, 32'h100, 32'h0, 0, 0);
    checkOutput("lw_mr", 32'(bus.mem_read), 32'd1);
    applyStimulus(1, 32'h010A4820, 32'h11, 32'h22, 0, 0);
    checkOutput("lu_stall",  32'(last_stall), 32'd1);
    checkOutput("lu_bubble", 32'(bus.issue_valid), 32'd0);
    applyStimulus(1, 32'h010A4820, 32'h11, 32'h22, 0, 0);
    checkOutput("lu_stall2", 32'(last_stall), 32'd0);
    checkOutput("lu_add_v",  32'(bus.issue_valid), 32'd1);
    checkOutput("lu_add_c",  32'(bus.alu_control), 32'd0);

    applyStimulus(1, 32'h8E000000, 32'h100, 32'h0, 0, 0);
    checkOutput("lw0_rw", 32'(bus.reg_write), 32'd0);
    applyStimulus(1, 32'h000A4820, 32'h0, 32'h5, 0, 0);
    checkOutput("lw0_stall", 32'(last_stall), 32'd0);

    applyStimulus(1, 32'h2008FFFB, 32'h1, 32'h2, 1, 1);
    checkOutput("flush_hold", 32'(bus.issue_valid), 32'd0);
    applyStimulus(1, 32'h2008FFFB, 32'h1, 32'h2, 0, 0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 32'h35498000, 32'h9, 32'h9, 1, 0);
      checkOutput("hold_ctrl", 32'(bus.alu_control), 32'd1);
      checkOutput("hold_b",    bus.alu_b, 32'hFFFF_FFFB);
    end

    applyStimulus(1, 32'hFC000000, 32'h0, 32'h0, 0, 0);
    checkOutput("undef_ill", 32'(bus.illegal), 32'd1);
    checkOutput("undef_v",   32'(bus.issue_valid), 32'd0);
    applyStimulus(1, 32'h00000000, 32'h0, 32'h0, 0, 0);
    checkOutput("nop_ill", 32'(bus.illegal), 32'd0);
    checkOutput("nop_v",   32'(bus.issue_valid), 32'd0);

    applyStimulus(1, 32'h2008FFFB, 32'h3, 32'h4, 0, 0);
    rst_n = 0;
    #1;
    checkOutput("arst_v",    32'(bus.issue_valid), 32'd0);
    checkOutput("arst_ctrl", 32'(bus.alu_control), 32'd0);
    checkOutput("arst_b",    bus.alu_b, 32'd0);
    bus.in_valid = 0;
    @(posedge clk);
    #1;
    rst_n = 1;

    for (int i = 0; i < 600; i++) begin
      int r;
      logic [31:0] w;
      r = $urandom_range(0, 99);
      if (r < 8)       w = $urandom;
      else if (r < 12) w = 32'd0;
      else if (r < 15) w = {6'h3F, 26'($urandom)};
      else             w = gen_instr($urandom_range(0, 29));
      applyStimulus($urandom_range(0, 99) < 88, w, $urandom, $urandom,
                    $urandom_range(0, 99) < 12, $urandom_range(0, 99) < 8);
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miss);
    $finish;
  end
endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX issue stage that drives the 32-bit ALU.
- Decodes the MIPS instruction held in IF/ID into the 5-bit ALU operation code and selects operands A, B and the shift amount.
- Detects load-use hazards and inserts a one-cycle bubble.
- Registers everything into the ID/EX pipeline register under a valid/hold/flush handshake.

Parameters:
- DATA_W, 32, operand/result width.
- ZERO_IS_NOP, 1, when 1 an all-zero instruction word issues as a bubble.

Ports:
- clk input 1: rising-edge clock.
- rst_n input 1: reset, asynchronous, active-low.
- in_valid input 1: IF/ID holds a real instruction.
- instr input 32: instruction word.
- rs_data input DATA_W: register-file value of rs.
- rt_data input DATA_W: register-file value of rt.
- hold_ex input 1: downstream stall; freeze the ID/EX register.
- flush input 1: kill the issuing instruction (taken branch/jump).
- stall_out output 1: combinational; IF/ID must hold its contents.
- issue_valid output 1: ID/EX holds a live instruction.
- alu_control output 5: ALU operation code.
- alu_a output DATA_W: operand A.
- alu_b output DATA_W: operand B.
- shamt output DATA_W: zero-extended instr[10:6].
- dest_reg output 5: write-back register.
- reg_write output 1: write-back enable.
- mem_read output 1: load.
- mem_write output 1: store.
- illegal output 1: one-cycle pulse, undefined encoding issued as bubble.

Behaviour:
- Reset (rst_n low, asynchronous): all registered outputs are 0, i.e. a bubble.

Opcode map. Fixed ALU codes; R-type is op 0 with the funct shown; mul is op 0x1C funct 0x02:
- add f20=0
- addi op08=1
- sub f22=2
- mul=3
- lw op23=4
- sw op2B=5
- sb op28=6
- lh op21=7
- lb op20=8
- sh op29=9
- bgez op01 rt=1 =10
- beq op04=11
- bne op05=12
- bgtz op07=13
- blez op06=14
- bltz op01 rt=0 =15
- j op02=16
- jr f08=17
- jal op03=18
- and f24=19
- andi op0C=20
- or f25=21
- nor f27=22
- xor f26=23
- ori op0D=24
- xori op0E=25
- sll f00=26
- srl f02=27
- slt f2A=28
- slti op0A=29

Operand selection:
- alu_a = rs_data.
- alu_b = rt_data for R-type, beq and bne; otherwise the immediate.
- andi, ori and xori zero-extend imm16; all other immediates sign-extend.

Destination and write-back:
- R-type writes rd (except jr).
- addi, andi, ori, xori, slti and loads write rt.
- jal writes 31.
- Stores, branches, j and jr have reg_write=0.
- reg_write is forced to 0 whenever dest_reg=0.

Load-use hazard:
- Condition: issue_valid & mem_read & dest_reg!=0 & in_valid & dest_reg matches a source register used by the incoming instruction.
- rs is a source for every instruction except j, jal, sll and srl.
- rt is a source for R-type, stores, beq and bne.
- On a hazard: stall_out=1 and the ID/EX register loads a bubble.
- The next cycle the bubble clears the hazard, so the stall lasts exactly one cycle.

Register update priority, per clk edge:
1. flush loads a bubble (overrides hold_ex).
2. hold_ex keeps all outputs unchanged.
3. hazard loads a bubble.
4. Otherwise load the decoded instruction, with issue_valid=in_valid.

Other rules:
- stall_out = hazard | hold_ex.
- The all-zero word (when ZERO_IS_NOP=1), in_valid=0 and undefined encodings all load a bubble.
- For an undefined encoding with in_valid=1 and no flush/hold, illegal=1 for one cycle.
- A bubble clears issue_valid, reg_write, mem_read, mem_write and alu_control.
- Latency: one cycle from IF/ID to ID/EX outputs.

Decomposition:
- Shared package alu_ops_pkg holds:
  - ALU code constants 0..29;
  - opcode and funct constants;
  - the source-usage helper function.
- Sub-module alu_op_decode is purely combinational: instruction in; code, immediate select/extend, dest, control flags and illegal out.
- The top level holds the hazard logic and the ID/EX register.

Test Plan:
- Reset, then `addi $t0,$zero,-5` (0x2008FFFB), in_valid=1 -> next cycle alu_control=1, alu_b=0xFFFFFFFB, dest_reg=8, reg_write=1, issue_valid=1.
- `ori` with imm 0x8000 -> alu_control=24, alu_b=0x00008000. `sll $t1,$t2,4` -> alu_control=26, shamt=4, dest_reg=9.
- `lw $t0,0($s0)` then `add $t1,$t0,$t2` -> stall_out=1 one cycle, bubble issued, then add issues with alu_control=0; total 3 cycles.
- `lw $zero` followed by a reader of $zero -> no stall; reg_write=0.
- flush and hold_ex both high with a valid instruction -> bubble loaded; hold_ex alone -> outputs frozen two cycles.
- Opcode 0x3F -> illegal pulses one cycle and issue_valid=0. 0x00000000 -> bubble, illegal=0. rst_n low mid-stream -> outputs 0 immediately.
